// File: rtl/forward_select_ctrl.sv
// Operand-forwarding select and issue-stall control: tracks in-flight producers
// per back-end stage and resolves each issuing operand to a bypass source.
module forward_select_ctrl #(
    parameter int PIPE_NUM   = 2,
    parameter int SOURCE_NUM = 3,
    parameter int REG_W      = 5
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic [PIPE_NUM-1:0]                             issue_valid_i,
    input  logic [PIPE_NUM-1:0][1:0][REG_W-1:0]             issue_rs_i,
    input  logic [PIPE_NUM-1:0][REG_W-1:0]                  issue_rd_i,
    input  logic [PIPE_NUM-1:0][$clog2(SOURCE_NUM+1)-1:0]   issue_rdy_stage_i,
    input  logic                                            advance_i,
    input  logic                                            flush_i,
    output logic [PIPE_NUM-1:0][1:0][((PIPE_NUM > 1) ? $clog2(PIPE_NUM) : 1)-1:0] fwd_pipe_sel_o,
    output logic [PIPE_NUM-1:0][1:0][SOURCE_NUM:0]          fwd_sel_vec_o,
    output logic                                            issue_stall_o,
    output logic [31:0]                                     stall_cnt_o
);

    localparam int RDY_W  = $clog2(SOURCE_NUM + 1);
    localparam int PSEL_W = (PIPE_NUM > 1) ? $clog2(PIPE_NUM) : 1;
    localparam int SEL_W  = SOURCE_NUM + 1;

    logic [PIPE_NUM-1:0] ent_vld [1:SOURCE_NUM];
    logic [REG_W-1:0]    ent_rd  [1:SOURCE_NUM][PIPE_NUM];
    logic [RDY_W-1:0]    ent_rdy [1:SOURCE_NUM][PIPE_NUM];
    logic [31:0]         stall_cnt_q;

    // Issue -> stage 1 boundary: a stalled bundle enters the back end as bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 1; s <= SOURCE_NUM; s++) begin
                ent_vld[s] <= '0;
            end
        end else if (flush_i) begin
            for (int s = 1; s <= SOURCE_NUM; s++) begin
                ent_vld[s] <= '0;
            end
        end else if (advance_i) begin
            for (int s = SOURCE_NUM; s >= 2; s--) begin
                ent_vld[s] <= ent_vld[s-1];
            end
            for (int p = 0; p < PIPE_NUM; p++) begin
                ent_vld[1][p] <= issue_valid_i[p] && !issue_stall_o && (issue_rd_i[p] != '0);
            end
        end
    end

    // Register/ready-stage payload only matters when its valid bit is set.
    always_ff @(posedge clk) begin
        if (advance_i && !flush_i) begin
            for (int s = SOURCE_NUM; s >= 2; s--) begin
                for (int p = 0; p < PIPE_NUM; p++) begin
                    ent_rd[s][p]  <= ent_rd[s-1][p];
                    ent_rdy[s][p] <= ent_rdy[s-1][p];
                end
            end
            for (int p = 0; p < PIPE_NUM; p++) begin
                ent_rd[1][p]  <= issue_rd_i[p];
                ent_rdy[1][p] <= issue_rdy_stage_i[p];
            end
        end
    end

    // Youngest stage first, highest pipe within a stage; the first match decides,
    // so an older ready copy never hides a younger producer that is still busy.
    always_comb begin
        logic hit;
        int   hit_s;
        int   hit_p;
        fwd_pipe_sel_o = '0;
        fwd_sel_vec_o  = '0;
        issue_stall_o  = 1'b0;
        for (int c = 0; c < PIPE_NUM; c++) begin
            for (int o = 0; o < 2; o++) begin
                hit   = 1'b0;
                hit_s = 1;
                hit_p = 0;
                if (issue_rs_i[c][o] != '0) begin
                    for (int s = 1; s <= SOURCE_NUM; s++) begin
                        for (int p = PIPE_NUM - 1; p >= 0; p--) begin
                            if (!hit && ent_vld[s][p] && (ent_rd[s][p] == issue_rs_i[c][o])) begin
                                hit   = 1'b1;
                                hit_s = s;
                                hit_p = p;
                            end
                        end
                    end
                end
                fwd_sel_vec_o[c][o] = SEL_W'(1);
                if (hit) begin
                    if (hit_s >= int'(ent_rdy[hit_s][hit_p])) begin
                        fwd_sel_vec_o[c][o]  = SEL_W'(1) << hit_s;
                        fwd_pipe_sel_o[c][o] = PSEL_W'(hit_p);
                    end else if (issue_valid_i[c]) begin
                        issue_stall_o = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (issue_stall_o && advance_i && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_forward_select_ctrl.sv
// Directed bench for forward_select_ctrl with hand-computed expectations.
module tb_forward_select_ctrl;

    localparam int PIPE_NUM   = 2;
    localparam int SOURCE_NUM = 3;
    localparam int REG_W      = 5;

    logic                       clk;
    logic                       rst_n;
    logic [1:0]                 issue_valid;
    logic [1:0][1:0][4:0]       issue_rs;
    logic [1:0][4:0]            issue_rd;
    logic [1:0][1:0]            issue_rdy;
    logic                       advance;
    logic                       flush;
    logic [1:0][1:0][0:0]       pipe_sel;
    logic [1:0][1:0][3:0]       sel_vec;
    logic                       stall;
    logic [31:0]                stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    forward_select_ctrl #(
        .PIPE_NUM  (PIPE_NUM),
        .SOURCE_NUM(SOURCE_NUM),
        .REG_W     (REG_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .issue_valid_i    (issue_valid),
        .issue_rs_i       (issue_rs),
        .issue_rd_i       (issue_rd),
        .issue_rdy_stage_i(issue_rdy),
        .advance_i        (advance),
        .flush_i          (flush),
        .fwd_pipe_sel_o   (pipe_sel),
        .fwd_sel_vec_o    (sel_vec),
        .issue_stall_o    (stall),
        .stall_cnt_o      (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        issue_valid = '0;
        issue_rs    = '0;
        issue_rd    = '0;
        issue_rdy   = '0;
        advance     = 1'b0;
        flush       = 1'b0;
    endtask

    // Apply the current inputs across one rising edge, then return 1 time unit after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int p, input logic [4:0] rd, input logic [1:0] rdy);
        issue_valid[p] = 1'b1;
        issue_rd[p]    = rd;
        issue_rdy[p]   = rdy;
    endtask

    task automatic do_flush();
        clr_in();
        flush   = 1'b1;
        advance = 1'b1;
        cyc();
        clr_in();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        clr_in();
        rst_n = 1'b0;
        issue_rs[0][0] = 5'd5;
        #1;
        check("rst_selvec", 32'(sel_vec[0][0]), 32'h1);
        check("rst_psel", 32'(pipe_sel[0][0]), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_cnt", stall_cnt, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clr_in();

        // pipe0 rd=5 ready at stage 1, consumed from stage 1 next cycle
        issue(0, 5'd5, 2'd1);
        advance = 1'b1;
        cyc();
        clr_in();
        issue_valid[1] = 1'b1;
        issue_rs[1][0] = 5'd5;
        #1;
        check("a_selvec", 32'(sel_vec[1][0]), 32'h2);
        check("a_psel", 32'(pipe_sel[1][0]), 32'h0);
        check("a_stall", 32'(stall), 32'h0);
        check("a_rs0_op", 32'(sel_vec[1][1]), 32'h1);
        do_flush();

        // load rd=7 ready at stage 3: two stalled advances then forward from stage 3
        issue(0, 5'd7, 2'd3);
        advance = 1'b1;
        cyc();
        clr_in();
        issue_valid[1] = 1'b1;
        issue_rs[1][0] = 5'd7;
        advance = 1'b1;
        #1;
        check("b_stall1", 32'(stall), 32'h1);
        check("b_selvec1", 32'(sel_vec[1][0]), 32'h1);
        cyc();
        check("b_stall2", 32'(stall), 32'h1);
        check("b_cnt1", stall_cnt, 32'd1);
        cyc();
        check("b_selvec3", 32'(sel_vec[1][0]), 32'h8);
        check("b_psel3", 32'(pipe_sel[1][0]), 32'h0);
        check("b_stall3", 32'(stall), 32'h0);
        check("b_cnt2", stall_cnt, 32'd2);
        do_flush();
        check("b_cnt_flush", stall_cnt, 32'd2);

        // rd=9 at stage 2 pipe0 and stage 1 pipe1: the younger one wins
        issue(0, 5'd9, 2'd1);
        advance = 1'b1;
        cyc();
        clr_in();
        issue(1, 5'd9, 2'd1);
        advance = 1'b1;
        cyc();
        clr_in();
        issue_valid[0] = 1'b1;
        issue_rs[0][0] = 5'd9;
        #1;
        check("c_selvec", 32'(sel_vec[0][0]), 32'h2);
        check("c_psel", 32'(pipe_sel[0][0]), 32'h1);
        do_flush();

        // rd=9 in both pipes of stage 1: highest pipe wins
        issue(0, 5'd9, 2'd1);
        issue(1, 5'd9, 2'd1);
        advance = 1'b1;
        cyc();
        clr_in();
        issue_valid[1] = 1'b1;
        issue_rs[1][1] = 5'd9;
        #1;
        check("d_selvec", 32'(sel_vec[1][1]), 32'h2);
        check("d_psel", 32'(pipe_sel[1][1]), 32'h1);
        do_flush();

        // younger not-ready rd=4 blocks an older ready rd=4; stall needs a valid consumer
        issue(0, 5'd4, 2'd1);
        advance = 1'b1;
        cyc();
        clr_in();
        issue(0, 5'd4, 2'd2);
        advance = 1'b1;
        cyc();
        clr_in();
        issue_valid[1] = 1'b1;
        issue_rs[1][0] = 5'd4;
        #1;
        check("e_block_stall", 32'(stall), 32'h1);
        check("e_block_selvec", 32'(sel_vec[1][0]), 32'h1);
        issue_valid[1] = 1'b0;
        #1;
        check("e_invalid_stall", 32'(stall), 32'h0);
        check("e_cnt", stall_cnt, 32'd2);
        do_flush();

        // flush while advancing kills an in-flight rd=3
        issue(0, 5'd3, 2'd1);
        advance = 1'b1;
        cyc();
        clr_in();
        flush   = 1'b1;
        advance = 1'b1;
        cyc();
        clr_in();
        issue_valid[0] = 1'b1;
        issue_rs[0][1] = 5'd3;
        #1;
        check("f_flush_selvec", 32'(sel_vec[0][1]), 32'h1);
        clr_in();

        // a producer issued in a stalled bundle becomes a bubble
        issue(0, 5'd7, 2'd3);
        advance = 1'b1;
        cyc();
        clr_in();
        issue(0, 5'd12, 2'd1);
        issue_valid[1] = 1'b1;
        issue_rs[1][0] = 5'd7;
        advance = 1'b1;
        #1;
        check("g_stall", 32'(stall), 32'h1);
        cyc();
        clr_in();
        issue_valid[1] = 1'b1;
        issue_rs[1][0] = 5'd12;
        #1;
        check("g_bubble_selvec", 32'(sel_vec[1][0]), 32'h1);
        check("g_bubble_stall", 32'(stall), 32'h0);
        check("g_cnt", stall_cnt, 32'd3);
        do_flush();

        // rd=0 creates no entry and rs=0 always reads the register file
        issue(0, 5'd0, 2'd1);
        advance = 1'b1;
        cyc();
        clr_in();
        issue_valid[1] = 1'b1;
        issue_rs[1][0] = 5'd0;
        #1;
        check("h_rs0_selvec", 32'(sel_vec[1][0]), 32'h1);
        check("h_rs0_psel", 32'(pipe_sel[1][0]), 32'h0);

        // reset mid-stream empties the table and clears the counter at once
        clr_in();
        issue(1, 5'd6, 2'd1);
        advance = 1'b1;
        cyc();
        clr_in();
        issue_valid[0] = 1'b1;
        issue_rs[0][0] = 5'd6;
        #1;
        check("i_pre_selvec", 32'(sel_vec[0][0]), 32'h2);
        check("i_pre_psel", 32'(pipe_sel[0][0]), 32'h1);
        rst_n = 1'b0;
        #1;
        check("i_rst_selvec", 32'(sel_vec[0][0]), 32'h1);
        check("i_rst_psel", 32'(pipe_sel[0][0]), 32'h0);
        check("i_rst_cnt", stall_cnt, 32'h0);
        check("i_rst_stall", 32'(stall), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/forward_select_ctrl.md
FORWARD_SELECT_CTRL -- requirements
Module: forward_select_ctrl

Interface
REQ-001 SHALL take parameter PIPE_NUM, default 2, the number of issue pipes.
REQ-002 SHALL take parameter SOURCE_NUM, default 3, the number of post-issue stages that can forward, stage 1 youngest.
REQ-003 SHALL take parameter REG_W, default 5, the register address width.
REQ-004 SHALL have a single clock domain; reset is asynchronous and active-low.
REQ-005 SHALL have port clk, input, 1 bit, the clock.
REQ-006 SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-007 SHALL have port issue_valid_i, input, [PIPE_NUM], the per-pipe issue-slot valid.
REQ-008 SHALL have port issue_rs_i, input, [PIPE_NUM][2][REG_W], the two source registers per pipe.
REQ-009 SHALL have port issue_rd_i, input, [PIPE_NUM][REG_W], the destination register per pipe, 0 meaning no write.
REQ-010 SHALL have port issue_rdy_stage_i, input, [PIPE_NUM][$clog2(SOURCE_NUM+1)], the first stage (1..SOURCE_NUM) at which the result is forwardable.
REQ-011 SHALL have port advance_i, input, 1 bit, the back-end pipeline advancing one stage this cycle.
REQ-012 SHALL have port flush_i, input, 1 bit, killing all in-flight producers.
REQ-013 SHALL have port fwd_pipe_sel_o, output, [PIPE_NUM][2][$clog2(PIPE_NUM)], the producer-pipe select for each operand's forwarding mux.
REQ-014 SHALL have port fwd_sel_vec_o, output, [PIPE_NUM][2][SOURCE_NUM+1], a one-hot select per operand, bit 0 meaning register-file data.
REQ-015 SHALL have port issue_stall_o, output, 1 bit, meaning an operand's producer is in flight but not yet forwardable.
REQ-016 SHALL have port stall_cnt_o, output, 32 bits, a saturating count of stalled cycles.

Function
REQ-017 SHALL hold a tracking table entry[s][p], with s in 1..SOURCE_NUM and p in 0..PIPE_NUM-1, each entry holding {valid, rd, rdy_stage}.
REQ-018 SHALL, on advance_i=1 with flush_i=0, shift entry[s+1] <= entry[s], drop entry[SOURCE_NUM], and load entry[1][p] from issue inputs.
REQ-019 SHALL set entry[1][p].valid on load only when issue_valid_i[p]=1, issue_stall_o=0 and issue_rd_i[p]!=0; otherwise entry[1][p] SHALL be a bubble.
REQ-020 SHALL hold the table unchanged on advance_i=0 with flush_i=0.
REQ-021 SHALL clear every valid bit on flush_i=1 regardless of advance_i, with flush taking priority.
REQ-022 SHALL compute the operand select combinationally from the registered table and the current issue_rs_i, with zero latency.
REQ-023 SHALL resolve an operand with rs=0, or with no matching valid entry, to sel_vec=...0001 and pipe_sel=0.
REQ-024 SHALL search stages youngest-first (s=1 up to SOURCE_NUM); within a stage, the highest pipe index SHALL win; the first match is the producer.
REQ-025 SHALL, when producer stage s >= rdy_stage, set sel_vec one-hot bit s and pipe_sel to the producer pipe.
REQ-026 SHALL, when producer stage s < rdy_stage, output sel_vec=...0001 and assert issue_stall_o; an older ready match SHALL NOT be used.
REQ-027 SHALL assert issue_stall_o only for operands of pipes with issue_valid_i=1.
REQ-028 SHALL always drive fwd_sel_vec_o exactly one-hot.
REQ-029 SHALL treat same-bundle RAW (pipe q reading pipe p<q's rd in the same bundle) as out of scope: the issue stage never presents it, and the block need not detect it.
REQ-030 SHALL increment stall_cnt_o on each cycle with issue_stall_o=1 and advance_i=1, saturating at 0xFFFFFFFF; flush SHALL NOT clear the counter.

Reset
REQ-031 SHALL, while rst_n=0, clear all table valid bits and set stall_cnt_o=0, both asynchronously.
REQ-032 SHALL, consequently in reset, drive every fwd_sel_vec_o=0001, fwd_pipe_sel_o=0 and issue_stall_o=0.
REQ-033 SHALL accept the first issue on the first rising edge after rst_n deasserts.

Verification
REQ-034 SHALL cover: pipe0 issues rd=5 with rdy_stage=1 and advance; next cycle pipe1 rs0=5 -> sel_vec=0010, pipe_sel=0, no stall.
REQ-035 SHALL cover: a load with rd=7 and rdy_stage=3 at stage 1, consumer rs=7 -> stall=1; after two more advances, at stage 3 -> sel_vec=1000, stall=0, stall_cnt_o=2.
REQ-036 SHALL cover: rd=9 in stage 2 pipe0 and in stage 1 pipe1 (both ready), consumer rs=9 -> sel_vec=0010, pipe_sel=1 (youngest wins).
REQ-037 SHALL cover: rd=9 in stage 1 pipe0 and in stage 1 pipe1 (both ready) -> pipe_sel=1.
REQ-038 SHALL cover: in-flight rd=3 followed by flush_i=1 with advance_i=1 -> next cycle rs=3 gives sel_vec=0001; a bubble loaded while stalled creates no entry.
REQ-039 SHALL cover: rs=0 while an in-flight rd=0 is issued -> sel_vec=0001; rst_n asserted mid-stream -> table empty and stall_cnt_o=0 immediately.
